// File: rtl/mips_pkg.sv
// MIPS instruction field positions, the NOP word and opcode classification
// shared by the prefetch register and anything downstream that decodes IR.
package mips_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int REG_W    = RS_MSB - RS_LSB + 1;
  localparam int FUNCT_W  = FUNCT_MSB - FUNCT_LSB + 1;
  localparam int IMM_W    = IMM_MSB - IMM_LSB + 1;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [OPCODE_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_e;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J
  } fmt_e;

  function automatic fmt_e decode_fmt(input logic [OPCODE_W-1:0] op);
    if (op == OP_RTYPE) return FMT_R;
    if (op == OP_J || op == OP_JAL) return FMT_J;
    return FMT_I;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Circular instruction queue: DEPTH words, head/tail pointers that wrap
// naturally, occupancy count, and a synchronous clear for branch flushes.
module ifb_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PW'(1);
      if (pop_i)  head_d = head_q + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset: contents are only observed behind a nonzero count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_prefetch_register.sv
// Instruction register fed by a prefetch queue, with empty-queue bypass,
// branch flush, stall indication and registered MIPS field decode.
module instruction_prefetch_register
  import mips_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_IR = DATA_W'(NOP),
  localparam int unsigned      CW       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   memory_out,
  output logic                mem_ready,
  input  logic                IRwrite,
  input  logic                flush,
  output logic [DATA_W-1:0]   instruction_register,
  output logic                ir_valid,
  output logic                stall,
  output logic [CW-1:0]       count,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNCT_W-1:0]  funct,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [IMM_W-1:0]    imm
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] head_word;
  logic [CW-1:0]     fifo_count;
  logic              empty;
  logic              push, pop, bypass;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;

  assign empty     = (fifo_count == '0);
  // No pop lookahead: a full queue refuses words even while IR pops the head.
  assign mem_ready = reset & (fifo_count < DEPTH_C);
  assign bypass    = IRwrite & ~flush & empty & mem_valid;
  assign pop       = IRwrite & ~flush & ~empty;
  assign push      = mem_valid & mem_ready & ~flush & ~bypass;
  assign stall     = IRwrite & empty & ~mem_valid & ~flush;

  ifb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (memory_out),
    .pop_i   (pop),
    .clear_i (flush),
    .rdata_o (head_word),
    .count_o (fifo_count)
  );

  always_comb begin
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    if (pop) begin
      ir_d       = head_word;
      ir_valid_d = 1'b1;
    end else if (bypass) begin
      ir_d       = memory_out;
      ir_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q       <= RESET_IR;
      ir_valid_q <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign instruction_register = ir_q;
  assign ir_valid             = ir_valid_q;
  assign count                = fifo_count;

  assign opcode = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign rs     = ir_q[RS_MSB:RS_LSB];
  assign rt     = ir_q[RT_MSB:RT_LSB];
  assign rd     = ir_q[RD_MSB:RD_LSB];
  assign funct  = ir_q[FUNCT_MSB:FUNCT_LSB];
  assign imm    = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instruction_prefetch_register.sv
// Directed and randomized checks of the prefetch register against a
// queue-based behavioural model of fetch, bypass, flush and IR load.
module tb_instruction_prefetch_register;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              mem_valid = 1'b0;
  logic [DATA_W-1:0] memory_out = '0;
  logic              mem_ready;
  logic              IRwrite = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] instruction_register;
  logic              ir_valid;
  logic              stall;
  logic [CW-1:0]     count;
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;

  instruction_prefetch_register #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_IR (32'h0000_0000)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .mem_valid            (mem_valid),
    .memory_out           (memory_out),
    .mem_ready            (mem_ready),
    .IRwrite              (IRwrite),
    .flush                (flush),
    .instruction_register (instruction_register),
    .ir_valid             (ir_valid),
    .stall                (stall),
    .count                (count),
    .opcode               (opcode),
    .funct                (funct),
    .rs                   (rs),
    .rt                   (rt),
    .rd                   (rd),
    .imm                  (imm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] model_q[$];
  logic [31:0] model_ir;
  logic        model_irv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ir"},     instruction_register, model_ir);
    check({tag, ".irv"},    {31'd0, ir_valid}, {31'd0, model_irv});
    check({tag, ".count"},  {29'd0, count}, model_q.size());
    check({tag, ".opcode"}, {26'd0, opcode}, {26'd0, model_ir[31:26]});
    check({tag, ".rs"},     {27'd0, rs}, {27'd0, model_ir[25:21]});
    check({tag, ".rt"},     {27'd0, rt}, {27'd0, model_ir[20:16]});
    check({tag, ".rd"},     {27'd0, rd}, {27'd0, model_ir[15:11]});
    check({tag, ".funct"},  {26'd0, funct}, {26'd0, model_ir[5:0]});
    check({tag, ".imm"},    {16'd0, imm}, {16'd0, model_ir[15:0]});
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model,
  // then check registered state just after the rising edge.
  task automatic cycle(input string tag, input logic irw, input logic mv,
                       input logic [31:0] data, input logic fl);
    logic exp_ready, exp_stall;
    int   sz;
    @(negedge clk);
    IRwrite = irw; mem_valid = mv; memory_out = data; flush = fl;
    #1;
    sz        = model_q.size();
    exp_ready = (sz < DEPTH);
    exp_stall = irw && sz == 0 && !mv && !fl;
    check({tag, ".ready"}, {31'd0, mem_ready}, {31'd0, exp_ready});
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
    if (fl) begin
      model_q.delete();
    end else if (irw && sz > 0) begin
      model_ir  = model_q.pop_front();
      model_irv = 1'b1;
      if (mv && exp_ready) model_q.push_back(data);
    end else if (irw && mv) begin
      model_ir  = data;
      model_irv = 1'b1;
    end else if (mv && exp_ready) begin
      model_q.push_back(data);
    end
    @(posedge clk);
    #1;
    check_state(tag);
    $display("txn %-8s irw=%0b mv=%0b fl=%0b data=%h -> ir=%h count=%0d", tag, irw, mv, fl,
             data, instruction_register, count);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_ir  = 32'h0;
    model_irv = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready_low", {31'd0, mem_ready}, 32'd0);
    check("rst.stall_low", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst.ready", {31'd0, mem_ready}, 32'd1);
    check_state("rst");

    // Bypass on empty queue
    cycle("bypass", 1'b1, 1'b1, 32'h0000_2008, 1'b0);
    check("bypass.imm", {16'd0, imm}, 32'h0000_2008);

    // Fill to full, 5th word held off
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b0, 1'b1, 32'h2001_0000 + i, 1'b0);
    check("full.count", {29'd0, count}, 32'd4);
    cycle("full5", 1'b0, 1'b1, 32'h2001_0005, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cycle("drain", 1'b1, 1'b0, 32'h0, 1'b0);
      check("drain.word", instruction_register, 32'h2001_0000 + i);
      check("drain.rt", {27'd0, rt}, 32'd1);
    end

    // Concurrent push/pop at count 2, across pointer wrap
    cycle("pre2", 1'b0, 1'b1, 32'hA000_0001, 1'b0);
    cycle("pre2", 1'b0, 1'b1, 32'hA000_0002, 1'b0);
    for (int i = 3; i <= 8; i++) begin
      cycle("pushpop", 1'b1, 1'b1, 32'hA000_0000 + i, 1'b0);
      check("pushpop.ir", instruction_register, 32'hA000_0000 + i - 2);
    end
    cycle("drain", 1'b1, 1'b0, 32'h0, 1'b0);
    cycle("drain", 1'b1, 1'b0, 32'h0, 1'b0);

    // Flush at count 3 with IRwrite and mem_valid
    for (int i = 0; i < 3; i++) cycle("pref", 1'b0, 1'b1, 32'hB000_0000 + i, 1'b0);
    cycle("flush", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check("flush.count", {29'd0, count}, 32'd0);

    // Stall then bypass
    cycle("stall", 1'b1, 1'b0, 32'h0, 1'b0);
    cycle("stallbyp", 1'b1, 1'b1, 32'h0123_4020, 1'b0);
    check("stallbyp.funct", {26'd0, funct}, 32'h20);
    check("stallbyp.rd", {27'd0, rd}, 32'd8);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      cycle("rand", ($urandom_range(99) < 45), ($urandom_range(99) < 60), $urandom,
            ($urandom_range(99) < 7));
    end

    // Asynchronous reset mid-operation
    cycle("prer", 1'b0, 1'b1, 32'hC000_0001, 1'b0);
    cycle("prer", 1'b1, 1'b1, 32'hC000_0002, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst.ready", {31'd0, mem_ready}, 32'd0);
    check_state("arst");
    @(negedge clk);
    reset = 1'b1;
    IRwrite = 1'b0; mem_valid = 1'b0; flush = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cycle("rand2", ($urandom_range(99) < 50), ($urandom_range(99) < 50), $urandom,
            ($urandom_range(99) < 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
